// File: rtl/audio_cond_pkg.sv
// Shared constants, pipeline payload types and a saturation helper for the audio conditioning stages.
package audio_cond_pkg;

   localparam int unsigned UNITY_GAIN = 128;
   localparam int unsigned GAIN_W     = 8;
   localparam int unsigned ACC_W      = 20;
   localparam int unsigned PCM_W      = 16;

   // Gain is Q1.7, so products carry 7 fractional bits to drop.
   localparam int unsigned GAIN_FRAC  = 7;
   localparam int unsigned PROD_W     = ACC_W + GAIN_W + 1;
   localparam int unsigned SCALED_W   = PROD_W - GAIN_FRAC;

   // Stage-1 payload: filtered (or bypassed) sample.
   typedef struct packed {
      logic             vld;
      logic [ACC_W-1:0] smp;
   } stage1_t;

   // Stage-2 payload: gain-scaled sample before output saturation.
   typedef struct packed {
      logic                vld;
      logic [SCALED_W-1:0] smp;
   } stage2_t;

   // Clamp a signed value to the range of an n-bit signed number.
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int unsigned n);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = $signed((32'd1 << (n - 1)) - 32'd1);
      lo = -hi - 32'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Fractional phase accumulator producing a one-cycle tick at SAMPLE_HZ from a CLK_HZ clock.
module sample_tick_gen #(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned SAMPLE_HZ = 48_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned ACC_BITS = $clog2(CLK_HZ) + 1;
   localparam int unsigned SUM_BITS = ACC_BITS + 1;
   localparam logic [SUM_BITS-1:0] STEP = SUM_BITS'(SAMPLE_HZ);
   localparam logic [SUM_BITS-1:0] WRAP = SUM_BITS'(CLK_HZ);

   logic [ACC_BITS-1:0] acc;
   logic [SUM_BITS-1:0] sum;

   // Candidate phase one step ahead, one bit wider so the wrap test cannot overflow.
   always_comb begin
      sum = SUM_BITS'(acc) + STEP;
   end

   // Advance the phase; wrap and fire the tick when a full clock period has accumulated.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (sum >= WRAP) begin
         acc  <= ACC_BITS'(sum - WRAP);
         tick <= 1'b1;
      end else begin
         acc  <= ACC_BITS'(sum);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/pcm_output_conditioner.sv
// Decimates the PCM stream to the sample grid, removes DC, applies a click-free ramped gain and saturates.
module pcm_output_conditioner
   import audio_cond_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned SAMPLE_HZ = 48_000,
   parameter int unsigned DC_SHIFT  = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [PCM_W-1:0] pcm_in,
   input  logic [3:0]              volume,
   input  logic                    mute,
   input  logic                    dc_bypass,
   output logic signed [PCM_W-1:0] audio_out,
   output logic                    audio_valid,
   output logic                    gain_settled
);

   localparam int unsigned WIDE_W = ACC_W + 1;

   logic                     tick;
   logic [GAIN_W-1:0]        tg;
   logic [GAIN_W-1:0]        g;
   logic [GAIN_W-1:0]        g_next;
   logic signed [ACC_W-1:0]  x_prev;
   logic signed [ACC_W-1:0]  y;
   logic signed [WIDE_W-1:0] y_sum;
   logic signed [ACC_W-1:0]  y_new;
   logic signed [ACC_W-1:0]  s1_next;
   logic signed [PROD_W-1:0] prod;
   stage1_t                  s1;
   stage2_t                  s2;

   sample_tick_gen #(
      .CLK_HZ   (CLK_HZ),
      .SAMPLE_HZ(SAMPLE_HZ)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // Target gain from the user controls; mute overrides, top step maps to exact unity.
   always_comb begin
      tg = '0;
      if (mute) begin
         tg = '0;
      end else if (volume == 4'd15) begin
         tg = GAIN_W'(UNITY_GAIN);
      end else begin
         tg = GAIN_W'({volume, 3'b000});
      end
   end

   assign gain_settled = (g == tg);

   // Single-step move of the current gain toward the target.
   always_comb begin
      g_next = g;
      if (g < tg) begin
         g_next = g + GAIN_W'(1);
      end else if (g > tg) begin
         g_next = g - GAIN_W'(1);
      end
   end

   // One-pole DC blocker evaluated one bit wide, then clamped back to the state width.
   always_comb begin
      y_sum   = WIDE_W'(pcm_in) - WIDE_W'(x_prev) + WIDE_W'(y) - (WIDE_W'(y) >>> DC_SHIFT);
      y_new   = ACC_W'(sat(32'(y_sum), ACC_W));
      s1_next = dc_bypass ? ACC_W'(pcm_in) : y_new;
   end

   // Stage 1: on a tick capture the sample, update filter state and step the gain ramp.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_prev <= '0;
         y      <= '0;
         g      <= '0;
         s1     <= '0;
      end else if (tick) begin
         x_prev <= ACC_W'(pcm_in);
         y      <= y_new;
         g      <= g_next;
         s1.vld <= 1'b1;
         s1.smp <= s1_next;
      end else begin
         s1.vld <= 1'b0;
      end
   end

   // Signed sample times unsigned Q1.7 gain, with the gain zero-extended to stay positive.
   always_comb begin
      prod = PROD_W'($signed(s1.smp)) * PROD_W'($signed({1'b0, g}));
   end

   // Stage 2: register the gain-scaled sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2 <= '0;
      end else begin
         s2.vld <= s1.vld;
         s2.smp <= SCALED_W'(prod >>> GAIN_FRAC);
      end
   end

   // Stage 3: saturate to the output width, hold between strobes and pulse valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         audio_out   <= '0;
         audio_valid <= 1'b0;
      end else begin
         audio_valid <= s2.vld;
         if (s2.vld) begin
            audio_out <= PCM_W'(sat(32'($signed(s2.smp)), PCM_W));
         end
      end
   end

endmodule

// File: tb/tb_pcm_output_conditioner.sv
// Scoreboard bench for pcm_output_conditioner, run with a scaled-down clock/sample ratio.
module tb_pcm_output_conditioner;

   localparam int TB_CLK    = 1000;
   localparam int TB_SAMPLE = 300;
   localparam int TB_DC     = 10;
   localparam int NO_EXP    = 1 << 20;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] pcm_in;
   logic [3:0]         volume;
   logic               mute;
   logic               dc_bypass;
   logic signed [15:0] audio_out;
   logic               audio_valid;
   logic               gain_settled;

   int vectors    = 0;
   int miscompares = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   pcm_output_conditioner #(
      .CLK_HZ   (TB_CLK),
      .SAMPLE_HZ(TB_SAMPLE),
      .DC_SHIFT (TB_DC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pcm_in      (pcm_in),
      .volume      (volume),
      .mute        (mute),
      .dc_bypass   (dc_bypass),
      .audio_out   (audio_out),
      .audio_valid (audio_valid),
      .gain_settled(gain_settled)
   );

   // Reference model: own tick accumulator, DC blocker, ramp and gain; pushes expected outputs.
   initial begin : model
      int m_acc, m_y, m_xp, m_g, m_tg, x, yn, s1, o;
      bit m_tick;
      m_acc = 0; m_y = 0; m_xp = 0; m_g = 0; m_tick = 1'b0;
      forever begin
         @(posedge clk);
         if (reset === 1'b1) begin
            m_acc = 0; m_y = 0; m_xp = 0; m_g = 0; m_tick = 1'b0;
            exp_q.delete();
         end else begin
            if (m_tick) begin
               m_tg = mute ? 0 : ((volume == 4'd15) ? 128 : int'(volume) * 8);
               if (m_g < m_tg) m_g++;
               else if (m_g > m_tg) m_g--;
               x  = int'(pcm_in);
               yn = x - m_xp + m_y - (m_y >>> TB_DC);
               if (yn > 524287) yn = 524287;
               if (yn < -524288) yn = -524288;
               s1 = dc_bypass ? x : yn;
               m_xp = x;
               m_y  = yn;
               o = (s1 * m_g) >>> 7;
               if (o > 32767) o = 32767;
               if (o < -32768) o = -32768;
               exp_q.push_back(o);
            end
            if (m_acc + TB_SAMPLE >= TB_CLK) begin
               m_acc  = m_acc + TB_SAMPLE - TB_CLK;
               m_tick = 1'b1;
            end else begin
               m_acc  = m_acc + TB_SAMPLE;
               m_tick = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for the next strobe and pop the matching expectation.
   task automatic get_sample(output bit got, output logic signed [15:0] val, output int ev);
      got = 1'b0;
      val = '0;
      ev  = NO_EXP;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (audio_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         val = audio_out;
         if (exp_q.size() > 0) ev = exp_q.pop_front();
      end
   endtask

   task automatic do_reset(input logic [3:0] vol, input logic mt, input logic byp, input logic signed [15:0] pcm);
      @(negedge clk);
      reset = 1'b1; volume = vol; mute = mt; dc_bypass = byp; pcm_in = pcm;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      int strobes;
      @(negedge clk);
      reset = 1'b1; volume = 4'd0; mute = 1'b0; dc_bypass = 1'b1; pcm_in = 16'sd1000;
      repeat (3) @(negedge clk);
      vectors++;
      if (audio_out !== 16'sd0) begin
         miscompares++; $display("FAIL reset_out: audio_out=%0d, expected 0", audio_out);
      end
      vectors++;
      if (audio_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_valid: audio_valid=%b, expected 0", audio_valid);
      end
      vectors++;
      if (gain_settled !== 1'b1) begin
         miscompares++; $display("FAIL reset_settled_tg0: gain_settled=%b, expected 1", gain_settled);
      end
      volume = 4'd15;
      #1;
      vectors++;
      if (gain_settled !== 1'b0) begin
         miscompares++; $display("FAIL reset_settled_tg128: gain_settled=%b, expected 0", gain_settled);
      end
      mute = 1'b1;
      #1;
      vectors++;
      if (gain_settled !== 1'b1) begin
         miscompares++; $display("FAIL reset_settled_mute: gain_settled=%b, expected 1", gain_settled);
      end
      mute = 1'b0;
      strobes = 0;
      repeat (20) begin
         @(negedge clk);
         if (audio_valid !== 1'b0) strobes++;
      end
      vectors++;
      if (strobes != 0) begin
         miscompares++; $display("FAIL reset_hold_strobes: %0d strobes while in reset, expected 0", strobes);
      end
      reset = 1'b0;
   endtask

   task automatic test_tick_rate;
      int cnt, first, last, bad;
      int min_sp, max_sp;
      min_sp = TB_CLK / TB_SAMPLE;
      max_sp = (TB_CLK + TB_SAMPLE - 1) / TB_SAMPLE;
      cnt = 0; first = 0; last = 0; bad = 0;
      do_reset(4'd15, 1'b0, 1'b1, 16'sd1000);
      for (int n = 1; n <= 10003; n++) begin
         @(negedge clk);
         if (audio_valid === 1'b1) begin
            cnt++;
            if (first == 0) first = n;
            else if ((n - last) < min_sp || (n - last) > max_sp) bad++;
            last = n;
         end
      end
      vectors++;
      if (first != max_sp + 3) begin
         miscompares++; $display("FAIL tick_first_strobe: first strobe after edge %0d, expected %0d", first, max_sp + 3);
      end
      vectors++;
      if (cnt != 3000) begin
         miscompares++; $display("FAIL tick_count: %0d strobes, expected 3000", cnt);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL tick_spacing: %0d spacings outside %0d..%0d, expected 0", bad, min_sp, max_sp);
      end
   endtask

   task automatic test_ramp_in;
      bit got; logic signed [15:0] val; int ev, dir;
      do_reset(4'd15, 1'b0, 1'b1, 16'sd1000);
      for (int k = 1; k <= 140; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL ramp_in_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
         dir = (k <= 128) ? ((1000 * k) >>> 7) : 1000;
         vectors++;
         if (32'(val) !== dir) begin
            miscompares++; $display("FAIL ramp_in_value k=%0d: audio_out=%0d, expected %0d", k, val, dir);
         end
         vectors++;
         if (gain_settled !== (k >= 128)) begin
            miscompares++; $display("FAIL ramp_in_settled k=%0d: gain_settled=%b, expected %b", k, gain_settled, k >= 128);
         end
      end
   endtask

   task automatic test_mute_ramp;
      bit got; logic signed [15:0] val; int ev, dir;
      do_reset(4'd15, 1'b0, 1'b1, 16'sd1000);
      for (int k = 1; k <= 130; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL mute_settle_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
      end
      mute = 1'b1;
      for (int k = 1; k <= 130; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL mute_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
         dir = (k <= 128) ? ((1000 * (128 - k)) >>> 7) : 0;
         vectors++;
         if (32'(val) !== dir) begin
            miscompares++; $display("FAIL mute_value k=%0d: audio_out=%0d, expected %0d", k, val, dir);
         end
         vectors++;
         if (gain_settled !== (k >= 128)) begin
            miscompares++; $display("FAIL mute_settled k=%0d: gain_settled=%b, expected %b", k, gain_settled, k >= 128);
         end
      end
      mute = 1'b0;
   endtask

   task automatic test_retarget;
      bit got; logic signed [15:0] val; int ev, gk, dir;
      do_reset(4'd15, 1'b0, 1'b1, 16'sd1000);
      for (int k = 1; k <= 20; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL retarget_up_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
      end
      volume = 4'd1;
      for (int k = 1; k <= 20; k++) begin
         get_sample(got, val, ev);
         gk  = (20 - k > 8) ? 20 - k : 8;
         dir = (1000 * gk) >>> 7;
         vectors++;
         if (!got || 32'(val) !== dir) begin
            miscompares++; $display("FAIL retarget_value k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, dir);
         end
         vectors++;
         if (gain_settled !== (gk == 8)) begin
            miscompares++; $display("FAIL retarget_settled k=%0d: gain_settled=%b, expected %b", k, gain_settled, gk == 8);
         end
      end
   endtask

   task automatic test_dc_removal;
      bit got; logic signed [15:0] val; int ev, prev;
      do_reset(4'd15, 1'b0, 1'b0, 16'sd0);
      for (int k = 1; k <= 135; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL dc_settle_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
      end
      pcm_in = 16'sd1000;
      get_sample(got, val, ev);
      vectors++;
      if (!got || 32'(val) !== 1000 || ev != 1000) begin
         miscompares++; $display("FAIL dc_step_up: audio_out=%0d model=%0d strobe=%0b, expected 1000", val, ev, got);
      end
      prev = 1000;
      for (int k = 1; k <= 60; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev || int'(val) > prev || val < 0) begin
            miscompares++; $display("FAIL dc_up_decay k=%0d: audio_out=%0d prev=%0d, expected %0d", k, val, prev, ev);
         end
         prev = int'(val);
      end
      pcm_in = -16'sd1000;
      get_sample(got, val, ev);
      vectors++;
      if (!got || 32'(val) !== -1000 || ev != -1000) begin
         miscompares++; $display("FAIL dc_step_down: audio_out=%0d model=%0d strobe=%0b, expected -1000", val, ev, got);
      end
      prev = -1000;
      for (int k = 1; k <= 1100; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev || int'(val) < prev || val > 0) begin
            miscompares++; $display("FAIL dc_down_decay k=%0d: audio_out=%0d prev=%0d, expected %0d", k, val, prev, ev);
         end
         prev = int'(val);
      end
      vectors++;
      if (prev < -10 || prev > 10) begin
         miscompares++; $display("FAIL dc_residual: audio_out=%0d, expected within +/-10", prev);
      end
   endtask

   task automatic test_saturation;
      bit got; logic signed [15:0] val; int ev, applied, dir;
      do_reset(4'd15, 1'b0, 1'b0, 16'sd0);
      for (int k = 1; k <= 135; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL sat_settle_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
      end
      applied = 32767;
      for (int k = 1; k <= 40; k++) begin
         pcm_in = 16'(applied);
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL sat_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
         dir = (applied > 0) ? 32767 : -32768;
         vectors++;
         if (32'(val) !== dir) begin
            miscompares++; $display("FAIL sat_clamp k=%0d: audio_out=%0d, expected %0d", k, val, dir);
         end
         applied = (applied > 0) ? -32768 : 32767;
      end
   endtask

   task automatic test_reset_mid_ramp;
      bit got; logic signed [15:0] val; int ev, dir;
      do_reset(4'd15, 1'b0, 1'b1, 16'sd1000);
      for (int k = 1; k <= 60; k++) begin
         get_sample(got, val, ev);
         vectors++;
         if (!got || 32'(val) !== ev) begin
            miscompares++; $display("FAIL midreset_pre_sb k=%0d: audio_out=%0d strobe=%0b, expected %0d", k, val, got, ev);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if (audio_out !== 16'sd0 || audio_valid !== 1'b0) begin
         miscompares++; $display("FAIL midreset_clear: audio_out=%0d audio_valid=%b, expected 0 and 0", audio_out, audio_valid);
      end
      vectors++;
      if (gain_settled !== 1'b0) begin
         miscompares++; $display("FAIL midreset_settled: gain_settled=%b, expected 0", gain_settled);
      end
      reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         get_sample(got, val, ev);
         dir = (1000 * k) >>> 7;
         vectors++;
         if (!got || 32'(val) !== dir || ev != dir) begin
            miscompares++; $display("FAIL midreset_restart k=%0d: audio_out=%0d model=%0d strobe=%0b, expected %0d", k, val, ev, got, dir);
         end
      end
   endtask

   // Scenario sequence.
   initial begin : stim
      reset = 1'b1; pcm_in = '0; volume = '0; mute = 1'b0; dc_bypass = 1'b1;
      test_reset();
      test_tick_rate();
      test_ramp_in();
      test_mute_ramp();
      test_retarget();
      test_dc_removal();
      test_saturation();
      test_reset_mid_ramp();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
